audio_clock_generator: RTL and testbench
========================================

AUDIO_CLOCK_GENERATOR -- requirements
Module: audio_clock_generator

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 8: width of the BCLK half-period divisor.
REQ-002 SHALL have parameter SLOT_WIDTH, default 32: BCLK periods per channel slot (8..32).
REQ-003 SHALL have parameter NUM_CHANNELS, default 2: slots per frame (even, 2..8; >2 is TDM).
REQ-004 SHALL have port InputCLK  in  1  sole clock (MMCM-derived audio clock); the block has one clock.
REQ-005 SHALL have port ResetN  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Enable  in  1  request to run or stop serial clocks.
REQ-007 SHALL have port DivHalf  in  DIV_WIDTH  BCLK half-period in InputCLK cycles.
REQ-008 SHALL have port Mode  in  1  0 = I2S (LRCLK one BCLK early), 1 = left-justified.
REQ-009 SHALL have port BCLK  out  1  bit clock, registered.
REQ-010 SHALL have port LRCLK  out  1  word select, registered.
REQ-011 SHALL have ports BCLKRise, BCLKFall  out  1 each  single-cycle strobes in the cycle BCLK changes.
REQ-012 SHALL have port FrameStart  out  1  single-cycle strobe at start of slot 0.
REQ-013 SHALL have ports SlotIndex (clog2(NUM_CHANNELS)) and BitIndex (clog2(SLOT_WIDTH))  out  current slot and bit, MSB-first.
REQ-014 SHALL have port Running  out  1  high while clocks are generated.

Function
REQ-015 Idle (Running=0): BCLK=0, LRCLK=0, strobes 0, SlotIndex=0, BitIndex=SLOT_WIDTH-1.
REQ-016 Idle and Enable=1 sampled at an edge: same edge sets Running=1, FrameStart=1, latches D=DivHalf (DivHalf=0 latched as 1) and Mode.
REQ-017 Half-period counter counts 0..D-1; at D-1 it wraps and toggles BCLK, pulsing BCLKRise or BCLKFall; first rise occurs D cycles after start.
REQ-018 Every BCLK fall SHALL decrement BitIndex; at 0 it wraps to SLOT_WIDTH-1 and SlotIndex increments; SlotIndex wraps NUM_CHANNELS-1 -> 0 with FrameStart=1.
REQ-019 Frame length SHALL be exactly 2*D*SLOT_WIDTH*NUM_CHANNELS InputCLK cycles.
REQ-020 LRCLK SHALL be 0 for slots 0..NUM_CHANNELS/2-1 and 1 for the rest.
REQ-021 Mode=1: LRCLK changes on the BCLK fall starting the first slot of each half; Mode=0: on the BCLK fall one bit earlier (BitIndex becomes 0 of the preceding slot).
REQ-022 DivHalf and Mode changes SHALL take effect only at the next FrameStart; mid-frame changes SHALL not perturb timing.
REQ-023 Enable=0 while running: current frame completes; at the fall that would start the next frame, BCLK stays 0, LRCLK=0, Running=0, FrameStart not pulsed.
REQ-024 Enable reasserted before that boundary: running continues with no gap and no extra FrameStart.
REQ-025 BCLKRise and BCLKFall SHALL never assert in the same cycle; no strobe SHALL assert while Running=0.

Reset
REQ-026 ResetN=0 SHALL asynchronously force all outputs to the REQ-015 idle values, clear counters, latch D=1 and Mode=0.
REQ-027 Reset mid-frame SHALL abort immediately; after release, restart obeys REQ-016.

Structure
REQ-028 Package audio_clk_pkg SHALL hold the Mode encoding constants (MODE_I2S, MODE_LJ) and parameter-range limits.
REQ-029 The half-period counter with toggle and strobe generation SHALL be a sub-module audio_bclk_divider; the frame/slot/bit sequencer stays in the top.

Verification
REQ-030 D=4, 2 ch, 32-bit, Mode=1: BCLK period 8 cycles, FrameStart every 512 cycles, LRCLK high 256 / low 256, toggling in the FrameStart cycle.
REQ-031 Same setup, Mode=0: LRCLK edges occur 8 cycles before each slot boundary; its period is unchanged at 512.
REQ-032 DivHalf 4 -> 2 written mid-frame: current frame stays 512 cycles; next frame 256 cycles, BCLK period 4.
REQ-033 Enable dropped at cycle 100 of a frame: BCLK stops low at cycle 512, Running=0 there; a re-raise at cycle 300 instead yields a seamless second frame.
REQ-034 NUM_CHANNELS=8, SLOT_WIDTH=16, D=1: SlotIndex 0..7, LRCLK high for slots 4..7, frame 256 cycles; DivHalf=0 behaves as D=1.
REQ-035 ResetN pulsed low mid-frame: outputs idle in the same cycle; restart after release produces FrameStart at the first Enable-sampled edge.

Source files
------------

// File: rtl/audio_clk_pkg.sv
// Shared constants for the audio clock generator: serial format encodings and
// the supported slot/channel ranges.
package audio_clk_pkg;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;

  localparam int SLOT_WIDTH_MIN   = 8;
  localparam int SLOT_WIDTH_MAX   = 32;
  localparam int NUM_CHANNELS_MIN = 2;
  localparam int NUM_CHANNELS_MAX = 8;

endpackage

// File: rtl/audio_bclk_divider.sv
// BCLK half-period divider: counts 0..div-1, toggles BCLK on wrap and emits
// registered rise/fall strobes plus a combinational "fall happens now" event.
module audio_bclk_divider
  import audio_clk_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 run_i,
  input  logic                 stop_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 bclk_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic                 fall_evt_o
);

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 bclk_q, bclk_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 tick_s;

  assign tick_s     = (cnt_q == (div_i - DIV_ONE));
  assign fall_evt_o = run_i & tick_s & bclk_q;

  // Next-state: hold low while idle or stopping (the stopping fall is silent).
  always_comb begin
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (!run_i || stop_i) begin
      cnt_d  = DIV_ZERO;
      bclk_d = 1'b0;
    end else if (tick_s) begin
      cnt_d  = DIV_ZERO;
      bclk_d = ~bclk_q;
      rise_d = ~bclk_q;
      fall_d = bclk_q;
    end else begin
      cnt_d  = cnt_q + DIV_ONE;
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= DIV_ZERO;
      bclk_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bclk_o = bclk_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/audio_clock_generator.sv
// Audio serial clock generator: BCLK/LRCLK plus frame/slot/bit sequencing for
// I2S, left-justified and TDM framing from a single audio clock.
module audio_clock_generator
  import audio_clk_pkg::*;
#(
  parameter int DIV_WIDTH    = 8,
  parameter int SLOT_WIDTH   = 32,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                            InputCLK,
  input  logic                            ResetN,
  input  logic                            Enable,
  input  logic [DIV_WIDTH-1:0]            DivHalf,
  input  logic                            Mode,
  output logic                            BCLK,
  output logic                            LRCLK,
  output logic                            BCLKRise,
  output logic                            BCLKFall,
  output logic                            FrameStart,
  output logic [$clog2(NUM_CHANNELS)-1:0] SlotIndex,
  output logic [$clog2(SLOT_WIDTH)-1:0]   BitIndex,
  output logic                            Running
);

  localparam int SLOT_W = $clog2(NUM_CHANNELS);
  localparam int BIT_W  = $clog2(SLOT_WIDTH);

  localparam logic [SLOT_W-1:0]    SLOT_ZERO = {SLOT_W{1'b0}};
  localparam logic [SLOT_W-1:0]    SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0]    LAST_SLOT = SLOT_W'(NUM_CHANNELS - 1);
  localparam logic [SLOT_W-1:0]    HALF_SLOT = SLOT_W'(NUM_CHANNELS / 2);
  localparam logic [BIT_W-1:0]     BIT_ZERO  = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]     BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]     LAST_BIT  = BIT_W'(SLOT_WIDTH - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO  = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

  logic                 running_q, running_d;
  logic                 fs_q, fs_d;
  logic                 lr_q, lr_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 mode_q, mode_d;

  logic                 fall_evt_s, start_s, frame_end_s, stop_s, lr_n_s;
  logic [SLOT_W-1:0]    slot_n_s, slot_after_s;
  logic [BIT_W-1:0]     bit_n_s;
  logic [DIV_WIDTH-1:0] div_eff_s;

  audio_bclk_divider #(.DIV_WIDTH(DIV_WIDTH)) u_bclk_div (
    .clk_i     (InputCLK),
    .rst_n_i   (ResetN),
    .run_i     (running_q),
    .stop_i    (stop_s),
    .div_i     (div_q),
    .bclk_o    (BCLK),
    .rise_o    (BCLKRise),
    .fall_o    (BCLKFall),
    .fall_evt_o(fall_evt_s)
  );

  assign start_s     = ~running_q & Enable;
  assign frame_end_s = fall_evt_s & (bit_q == BIT_ZERO) & (slot_q == LAST_SLOT);
  assign stop_s      = frame_end_s & ~Enable;
  assign div_eff_s   = (DivHalf == DIV_ZERO) ? DIV_ONE : DivHalf;

  // Position after the next BCLK fall, and the slot following that one.
  always_comb begin
    bit_n_s  = bit_q - BIT_ONE;
    slot_n_s = slot_q;
    if (bit_q == BIT_ZERO) begin
      bit_n_s  = LAST_BIT;
      slot_n_s = (slot_q == LAST_SLOT) ? SLOT_ZERO : (slot_q + SLOT_ONE);
    end else begin
      bit_n_s  = bit_q - BIT_ONE;
    end
    slot_after_s = (slot_n_s == LAST_SLOT) ? SLOT_ZERO : (slot_n_s + SLOT_ONE);
  end

  // I2S leads the word select by one bit: it follows the slot about to begin.
  always_comb begin
    lr_n_s = (slot_n_s >= HALF_SLOT);
    if (mode_q == MODE_LJ) begin
      lr_n_s = (slot_n_s >= HALF_SLOT);
    end else if (bit_n_s == BIT_ZERO) begin
      lr_n_s = (slot_after_s >= HALF_SLOT);
    end else begin
      lr_n_s = (slot_n_s >= HALF_SLOT);
    end
  end

  // Sequencer next-state: start, stop at a frame boundary, or advance on a fall.
  always_comb begin
    running_d = running_q;
    fs_d      = 1'b0;
    lr_d      = lr_q;
    slot_d    = slot_q;
    bit_d     = bit_q;
    div_d     = div_q;
    mode_d    = mode_q;
    if (start_s) begin
      running_d = 1'b1;
      fs_d      = 1'b1;
      lr_d      = 1'b0;
      slot_d    = SLOT_ZERO;
      bit_d     = LAST_BIT;
      div_d     = div_eff_s;
      mode_d    = Mode;
    end else if (stop_s) begin
      running_d = 1'b0;
      lr_d      = 1'b0;
      slot_d    = SLOT_ZERO;
      bit_d     = LAST_BIT;
    end else if (fall_evt_s) begin
      bit_d  = bit_n_s;
      slot_d = slot_n_s;
      lr_d   = lr_n_s;
      if (frame_end_s) begin
        fs_d   = 1'b1;
        div_d  = div_eff_s;
        mode_d = Mode;
      end else begin
        fs_d   = 1'b0;
      end
    end else begin
      fs_d = 1'b0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge InputCLK or negedge ResetN) begin
    if (!ResetN) begin
      running_q <= 1'b0;
      fs_q      <= 1'b0;
      lr_q      <= 1'b0;
      slot_q    <= SLOT_ZERO;
      bit_q     <= LAST_BIT;
      div_q     <= DIV_ONE;
      mode_q    <= MODE_I2S;
    end else begin
      running_q <= running_d;
      fs_q      <= fs_d;
      lr_q      <= lr_d;
      slot_q    <= slot_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
    end
  end

  assign Running    = running_q;
  assign FrameStart = fs_q;
  assign LRCLK      = lr_q;
  assign SlotIndex  = slot_q;
  assign BitIndex   = bit_q;

endmodule

// File: tb/tb_audio_clock_generator.sv
// Scoreboard bench: stimulus queues expected per-frame measurements, a monitor
// measures each frame between FrameStart strobes (or stop) and compares.
module tb_audio_clock_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, mode, en8, mode8;
  logic [7:0] div, div8;
  logic       bclk, lrclk, rise, fall, fs, run;
  logic [0:0] slot;
  logic [4:0] bitx;
  logic       bclk8, lrclk8, rise8, fall8, fs8, run8;
  logic [2:0] slot8;
  logic [3:0] bit8;

  typedef struct {
    int len;
    int lr_rise;
    int lr_high;
    int rises;
    int max_slot;
    int stopped;
  } frame_exp_t;

  frame_exp_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  viol     = 0;
  bit  sel      = 1'b0;

  audio_clock_generator #(.DIV_WIDTH(8), .SLOT_WIDTH(32), .NUM_CHANNELS(2)) dut (
    .InputCLK(clk), .ResetN(rst_n), .Enable(en), .DivHalf(div), .Mode(mode),
    .BCLK(bclk), .LRCLK(lrclk), .BCLKRise(rise), .BCLKFall(fall),
    .FrameStart(fs), .SlotIndex(slot), .BitIndex(bitx), .Running(run)
  );

  audio_clock_generator #(.DIV_WIDTH(8), .SLOT_WIDTH(16), .NUM_CHANNELS(8)) dut8 (
    .InputCLK(clk), .ResetN(rst_n), .Enable(en8), .DivHalf(div8), .Mode(mode8),
    .BCLK(bclk8), .LRCLK(lrclk8), .BCLKRise(rise8), .BCLKFall(fall8),
    .FrameStart(fs8), .SlotIndex(slot8), .BitIndex(bit8), .Running(run8)
  );

  task automatic cmp(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic push(input int len, input int lr_rise, input int lr_high,
                      input int rises, input int max_slot, input int stopped);
    frame_exp_t e;
    e.len = len; e.lr_rise = lr_rise; e.lr_high = lr_high;
    e.rises = rises; e.max_slot = max_slot; e.stopped = stopped;
    exp_q.push_back(e);
  endtask

  task automatic wait_fs(input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (sel ? fs8 : fs) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL wait_frame_start: no FrameStart within %0d cycles", bound);
    end
  endtask

  task automatic wait_idle(input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (!(sel ? run8 : run)) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL wait_idle: Running still high after %0d cycles", bound);
    end
  endtask

  task automatic check_idle(input string tag);
    cmp({tag, "_bclk"}, int'(bclk), 0);
    cmp({tag, "_lrclk"}, int'(lrclk), 0);
    cmp({tag, "_running"}, int'(run), 0);
    cmp({tag, "_framestart"}, int'(fs), 0);
    cmp({tag, "_strobes"}, int'(rise) + int'(fall), 0);
    cmp({tag, "_slot"}, int'(slot), 0);
    cmp({tag, "_bit"}, int'(bitx), 31);
  endtask

  // Frame monitor: measures each frame and compares against the queued expectation.
  initial begin
    bit open;
    int off, lr_rise, lr_high, rises, max_slot, m_slot;
    logic m_fs, m_run, m_lr, m_rise, m_bclk;
    frame_exp_t e;
    open = 1'b0; off = 0; lr_rise = -1; lr_high = 0; rises = 0; max_slot = 0;
    forever begin
      @(negedge clk);
      m_fs   = sel ? fs8 : fs;
      m_run  = sel ? run8 : run;
      m_lr   = sel ? lrclk8 : lrclk;
      m_rise = sel ? rise8 : rise;
      m_bclk = sel ? bclk8 : bclk;
      m_slot = sel ? int'(slot8) : int'(slot);
      if (!rst_n) begin
        open = 1'b0;
      end else begin
        if (open && (m_fs || !m_run)) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL frame_unexpected: got frame of %0d cycles, expected none", off);
          end else begin
            e = exp_q.pop_front();
            cmp("frame_len", off, e.len);
            cmp("frame_lr_rise", lr_rise, e.lr_rise);
            cmp("frame_lr_high", lr_high, e.lr_high);
            cmp("frame_bclk_rises", rises, e.rises);
            cmp("frame_max_slot", max_slot, e.max_slot);
            cmp("frame_end_by_stop", m_fs ? 0 : 1, e.stopped);
            if (!m_fs) begin
              cmp("stop_bclk", int'(m_bclk), 0);
              cmp("stop_lrclk", int'(m_lr), 0);
            end
          end
          open = 1'b0;
        end
        if (m_fs) begin
          open = 1'b1; off = 0; lr_rise = -1; lr_high = 0; rises = 0; max_slot = 0;
        end
        if (open) begin
          if (m_lr && lr_rise < 0) lr_rise = off;
          lr_high += int'(m_lr);
          rises   += int'(m_rise);
          if (m_slot > max_slot) max_slot = m_slot;
          off++;
        end
      end
    end
  end

  // Protocol watcher: strobe exclusivity and quiet outputs while idle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rise && fall) viol++;
        if (!run && (rise || fall || fs || bclk || lrclk)) viol++;
        if (rise8 && fall8) viol++;
        if (!run8 && (rise8 || fall8 || fs8 || bclk8 || lrclk8)) viol++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; div = 8'd4; mode = 1'b1;
    en8 = 1'b0; div8 = 8'd0; mode8 = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    cmp("reset8_bit", int'(bit8), 15);
    cmp("reset8_running", int'(run8), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // F1: left-justified, D=4; mode switch mid-frame applies to F2 only
    en = 1'b1;
    push(512, 256, 256, 64, 1, 0);
    wait_fs(20);
    repeat (100) @(posedge clk);
    #1 mode = 1'b0;
    push(512, 248, 256, 64, 1, 0);
    wait_fs(600);
    // F2: I2S, D=4; divisor change mid-frame applies to F3
    repeat (100) @(posedge clk);
    #1 div = 8'd2;
    push(256, 124, 128, 64, 1, 0);
    wait_fs(600);
    // F3: I2S, D=2; restore D=4 left-justified for F4
    repeat (50) @(posedge clk);
    #1 div = 8'd4; mode = 1'b1;
    push(512, 256, 256, 64, 1, 0);
    wait_fs(300);
    // F4: Enable dropped at ~100 and re-raised at ~300 -> seamless
    repeat (100) @(posedge clk);
    #1 en = 1'b0;
    repeat (200) @(posedge clk);
    #1 en = 1'b1;
    push(512, 256, 256, 64, 1, 1);
    wait_fs(600);
    // F5: Enable dropped at ~100 and kept low -> stops at the frame boundary
    repeat (100) @(posedge clk);
    #1 en = 1'b0;
    wait_idle(600);
    repeat (5) @(posedge clk);
    #1;
    cmp("after_stop_running", int'(run), 0);
    cmp("after_stop_bclk", int'(bclk), 0);
    cmp("after_stop_bit", int'(bitx), 31);

    // Reset mid-frame, then restart with Enable held high
    en = 1'b1;
    wait_fs(20);
    repeat (300) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_idle("rst_mid");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push(512, 256, 256, 64, 1, 1);
    @(posedge clk); #1;
    cmp("restart_framestart", int'(fs), 1);
    cmp("restart_running", int'(run), 1);
    repeat (10) @(posedge clk);
    #1 en = 1'b0;
    wait_idle(700);
    repeat (3) @(posedge clk);

    // 8-slot TDM, 16-bit slots, DivHalf=0 treated as D=1
    #1 sel = 1'b1;
    en8 = 1'b1;
    push(256, 128, 128, 128, 7, 0);
    push(256, 128, 128, 128, 7, 1);
    wait_fs(20);
    wait_fs(300);
    repeat (10) @(posedge clk);
    #1 en8 = 1'b0;
    wait_idle(300);
    repeat (3) @(posedge clk);

    cmp("scoreboard_empty", exp_q.size(), 0);
    cmp("protocol_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
